addsub_iter: RTL and testbench
==============================

ADDSUB_ITER -- requirements
Module: addsub_iter

Interface
REQ-001 Parameter WIDTH, default 8: width of operand A, result Y and the internal datapath.
REQ-002 Parameter BW, default WIDTH: width of operand B, 1 <= BW <= WIDTH; B is zero-extended to WIDTH.
REQ-003 Parameter CHUNK, default 2: bits processed per cycle; WIDTH % CHUNK == 0 is checked at elaboration; N = WIDTH/CHUNK.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request to begin an operation.
REQ-007 op  input  1  operation select: 0 = add (A+B), 1 = subtract (A-B).
REQ-008 a  input  WIDTH  operand A, two's complement.
REQ-009 b  input  BW  operand B, unsigned, zero-extended.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 y  output  WIDTH  registered result.
REQ-013 c_out  output  1  carry out of the MSB; for subtract, 1 = no borrow.
REQ-014 v_out  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-015 n_out  output  1  y[WIDTH-1] of the last result.
REQ-016 z_out  output  1  high when the last result y == 0.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 In IDLE or DONE, start=1 at a rising edge SHALL latch a, zero-extended b and op, clear the chunk counter, set the running carry to op (1 for subtract), and enter RUN.
REQ-019 For subtract, the B operand SHALL be the bitwise inverse of zero-extended B, giving A + ~B + 1.
REQ-020 Each RUN cycle SHALL ripple-add one CHUNK-bit slice, LSB slice first, store the slice into the result shift register, and register the slice carry-out as the next running carry.
REQ-021 When processing the top slice, the block SHALL capture the carry into bit WIDTH-1 for use in v_out.
REQ-022 After the N-th RUN edge, the block SHALL update y, c_out, v_out, n_out and z_out together, enter DONE, and assert done for exactly one cycle.
REQ-023 Latency: done SHALL be high in the cycle beginning N rising edges after the edge that sampled start.
REQ-024 From DONE, with no start, the FSM SHALL return to IDLE on the next edge.
REQ-025 busy SHALL be 1 exactly while in RUN; done SHALL be 1 exactly while in DONE.
REQ-026 start while in RUN SHALL be ignored: no relatch and no change to the operation in progress.
REQ-027 start while in DONE SHALL begin a new operation back-to-back, with done still pulsing for the completed one.
REQ-028 y and all flags SHALL hold their values from the last completion until the next completion; they SHALL NOT show partial results.
REQ-029 All arithmetic SHALL be modulo 2^WIDTH, and c_out SHALL be the WIDTH-th bit of the sum.

Reset
REQ-030 While rst_n=0, the state SHALL be IDLE and busy, done, y, c_out, v_out, n_out, counter and carry SHALL be 0.
REQ-031 z_out SHALL reset to 1, consistent with y=0.
REQ-032 Reset asserted during RUN SHALL abort the operation immediately, with no done pulse.

Structure
REQ-033 Package alu_pkg SHALL hold the op encoding (OP_ADD=0, OP_SUB=1) and the FSM state enum.
REQ-034 A combinational sub-module addsub_chunk (CHUNK-bit ripple adder with cin, cout and MSB carry-in) SHALL be instantiated once.
REQ-035 The counter width SHALL be $clog2(N), minimum 1.

Verification (WIDTH=8, BW=8, CHUNK=2, N=4)
REQ-036 sub 8'h05 - 8'h03 -> done 4 edges after start, y=8'h02, C=1, V=0, N=0, Z=0.
REQ-037 sub 8'h80 - 8'h01 -> y=8'h7F, C=1, V=1, N=0; and sub 8'h00 - 8'h01 -> y=8'hFF, C=0, V=0, N=1.
REQ-038 add 8'h7F + 8'h01 -> y=8'h80, V=1, N=1, C=0; and add 8'hFF + 8'h01 -> y=8'h00, C=1, Z=1.
REQ-039 start pulsed with new operands during RUN -> result still reflects the first operands, and exactly one done pulse occurs.
REQ-040 start asserted in the DONE cycle -> second result 4 edges later; y holds the first result until then.
REQ-041 rst_n low for one cycle mid-RUN -> no done pulse, all outputs at reset values, busy=0; next start completes normally.
REQ-042 BW=2 instance: sub 4'h0 - 2'h1 with WIDTH=4, CHUNK=1 -> y=4'hF, C=0, V=0, done after 4 edges.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg -- shared op encoding and FSM state type for addsub_iter | Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/addsub_chunk.sv
// ============================================================================
// addsub_chunk -- CHUNK-bit combinational ripple adder slice         | Rev 1.0
// ============================================================================
`default_nettype none

module addsub_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] w_c;

    // cmsb_o is the carry into the slice MSB; only meaningful on the top slice
    always_comb begin
        w_c    = '0;
        sum_o  = '0;
        w_c[0] = cin_i;
        for (int i = 0; i < CHUNK; i++) begin
            sum_o[i]  = a_i[i] ^ b_i[i] ^ w_c[i];
            w_c[i+1]  = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = w_c[CHUNK];
        cmsb_o = w_c[CHUNK-1];
    end

endmodule

`default_nettype wire

// File: rtl/addsub_iter.sv
// ============================================================================
// addsub_iter -- iterative add/subtract, CHUNK bits per cycle, with flags | Rev 1.0
// ============================================================================
`default_nettype none

module addsub_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BW    = WIDTH,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [BW-1:0]    b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             c_out,
    output logic             v_out,
    output logic             n_out,
    output logic             z_out
);

    localparam int             N        = WIDTH / CHUNK;
    localparam int             CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

    if (WIDTH % CHUNK != 0) begin : g_chk_chunk
        $error("addsub_iter: WIDTH must be a multiple of CHUNK");
    end
    if (BW < 1 || BW > WIDTH) begin : g_chk_bw
        $error("addsub_iter: BW must lie in 1..WIDTH");
    end

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               c_q, c_d, v_q, v_d, n_q, n_d, z_q, z_d;

    logic [WIDTH-1:0]   w_b_ext;
    logic [CHUNK-1:0]   w_sum;
    logic               w_cout;
    logic               w_cmsb;
    logic [WIDTH-1:0]   w_sr_next;

    assign w_b_ext = WIDTH'(b);

    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i    (a_q[CHUNK-1:0]),
        .b_i    (b_q[CHUNK-1:0]),
        .cin_i  (carry_q),
        .sum_o  (w_sum),
        .cout_o (w_cout),
        .cmsb_o (w_cmsb)
    );

    // Slices enter at the top and shift down, so after N cycles the LSB slice sits at bit 0
    assign w_sr_next = (sr_q >> CHUNK) | (WIDTH'(w_sum) << (WIDTH - CHUNK));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sr_d    = sr_q;
        y_d     = y_q;
        c_d     = c_q;
        v_d     = v_q;
        n_d     = n_q;
        z_d     = z_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = (op == OP_SUB) ? ~w_b_ext : w_b_ext;
                    cnt_d   = '0;
                    carry_d = op;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                sr_d    = w_sr_next;
                carry_d = w_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    y_d     = w_sr_next;
                    c_d     = w_cout;
                    v_d     = w_cmsb ^ w_cout;
                    n_d     = w_sr_next[WIDTH-1];
                    z_d     = (w_sr_next == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sr_q    <= '0;
            y_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sr_q    <= sr_d;
            y_q     <= y_d;
            c_q     <= c_d;
            v_q     <= v_d;
            n_q     <= n_d;
            z_q     <= z_d;
        end
    end

    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign y     = y_q;
    assign c_out = c_q;
    assign v_out = v_q;
    assign n_out = n_q;
    assign z_out = z_q;

endmodule

`default_nettype wire

// File: tb/tb_addsub_iter.sv
// ============================================================================
// tb_addsub_iter -- directed self-checking bench for addsub_iter     | Rev 1.0
// ============================================================================
`default_nettype none

module tb_addsub_iter;

    logic       clk;
    logic       rst_n;
    logic       start, op;
    logic [7:0] a, b, y;
    logic       busy, done, c_out, v_out, n_out, z_out;

    logic       start2, op2;
    logic [3:0] a2, y2;
    logic [1:0] b2;
    logic       busy2, done2, c2, v2, n2, z2;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] last_y = 8'h00;

    addsub_iter #(.WIDTH(8), .BW(8), .CHUNK(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .y(y),
        .c_out(c_out), .v_out(v_out), .n_out(n_out), .z_out(z_out)
    );

    addsub_iter #(.WIDTH(4), .BW(2), .CHUNK(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .op(op2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .y(y2),
        .c_out(c2), .v_out(v2), .n_out(n2), .z_out(z2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts in whatever cycle the caller is in; returns in the DONE cycle
    task automatic run_op(input logic o, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ey, input logic ec, input logic ev,
                          input logic en, input logic ez);
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k < 4) begin
                chk("done_early", done, 0);
                chk("y_hold", y, last_y);
            end else begin
                chk("done_latency", done, 1);
                chk("busy_in_done", busy, 0);
                chk("y", y, ey);
                chk("c_out", c_out, ec);
                chk("v_out", v_out, ev);
                chk("n_out", n_out, en);
                chk("z_out", z_out, ez);
            end
        end
        last_y = ey;
    endtask

    task automatic chk_idle();
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
    endtask

    initial begin
        int n_done;
        logic [7:0] y_at_done;
        int k_done;

        rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        start2 = 1'b0; op2 = 1'b0; a2 = '0; b2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_y", y, 8'h00);
        chk("rst_c", c_out, 0);
        chk("rst_v", v_out, 0);
        chk("rst_n", n_out, 0);
        chk("rst_z", z_out, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic arithmetic and flag corner cases
        run_op(1'b1, 8'h05, 8'h03, 8'h02, 1, 0, 0, 0);
        chk_idle();
        run_op(1'b1, 8'h80, 8'h01, 8'h7F, 1, 1, 0, 0);
        chk_idle();
        run_op(1'b1, 8'h00, 8'h01, 8'hFF, 0, 0, 1, 0);
        chk_idle();
        run_op(1'b0, 8'h7F, 8'h01, 8'h80, 0, 1, 1, 0);
        chk_idle();
        run_op(1'b0, 8'hFF, 8'h01, 8'h00, 1, 0, 0, 1);
        chk_idle();

        // start pulsed mid-RUN with new operands must be ignored
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 8'h10; b = 8'h20;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0; k_done = 0; y_at_done = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin
                start = 1'b1; op = 1'b1; a = 8'h55; b = 8'h55;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                n_done++;
                k_done = k;
                y_at_done = y;
            end
        end
        chk("ignore_start_done_count", n_done, 1);
        chk("ignore_start_done_edge", k_done, 4);
        chk("ignore_start_y", y_at_done, 8'h30);
        last_y = 8'h30;

        // Back-to-back: second start lands in the DONE cycle of the first
        run_op(1'b0, 8'h01, 8'h02, 8'h03, 0, 0, 0, 0);
        run_op(1'b1, 8'h09, 8'h04, 8'h05, 1, 0, 0, 0);
        chk_idle();

        // Reset mid-RUN aborts without a done pulse
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 8'h11; b = 8'h22;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_y", y, 8'h00);
        chk("abort_c", c_out, 0);
        chk("abort_v", v_out, 0);
        chk("abort_n", n_out, 0);
        chk("abort_z", z_out, 1);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        last_y = 8'h00;
        run_op(1'b0, 8'h40, 8'h40, 8'h80, 0, 1, 1, 0);
        chk_idle();

        // Narrow-B instance: 4'h0 - 2'h1 with one bit per cycle
        @(negedge clk);
        start2 = 1'b1; op2 = 1'b1; a2 = 4'h0; b2 = 2'h1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("w4_busy", busy2, 1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k < 4) begin
                chk("w4_done_early", done2, 0);
                chk("w4_y_hold", y2, 4'h0);
            end else begin
                chk("w4_done_latency", done2, 1);
                chk("w4_y", y2, 4'hF);
                chk("w4_c", c2, 0);
                chk("w4_v", v2, 0);
                chk("w4_n", n2, 1);
                chk("w4_z", z2, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
